// File: rtl/serial_group_subtractor_if.sv
// Operand/result handshake bundle for serial_group_subtractor.
// Defining SUB_OVERFLOW_EN adds the signed overflow flag ovf.
interface serial_group_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
`endif
endinterface

// File: rtl/serial_group_subtractor.sv
// Multi-cycle A - B, one GROUP-bit carry-lookahead slice per clock.
// Define SUB_OVERFLOW_EN to add the signed overflow output ovf.
module serial_group_subtractor #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input logic                      clk,
  input logic                      rst,
  serial_group_subtractor_if.slave bus
);

  localparam int NSLICE = WIDTH / GROUP;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opBInv_q, opBInv_d;
  logic [WIDTH-1:0] accum_q, accum_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] sliceCnt_q, sliceCnt_d;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  int unsigned      sliceBase;
  logic [GROUP-1:0] sliceA, sliceB, gen, prop, sliceSum;
  logic [GROUP:0]   c;

  // Lookahead slice: c[0] is the carry chained from the previous slice.
  always_comb begin
    sliceBase = 32'(sliceCnt_q) * 32'(GROUP);
    sliceA    = opA_q[sliceBase +: GROUP];
    sliceB    = opBInv_q[sliceBase +: GROUP];
    gen       = sliceA & sliceB;
    prop      = sliceA ^ sliceB;
    c         = '0;
    c[0]      = carry_q;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = gen[i] | (prop[i] & c[i]);
    end
    sliceSum = prop ^ c[GROUP-1:0];
  end

  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opBInv_d   = opBInv_q;
    accum_d    = accum_q;
    diff_d     = diff_q;
    carry_d    = carry_q;
    borrow_d   = borrow_q;
    sliceCnt_d = sliceCnt_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d      = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opA_d      = bus.a;
          opBInv_d   = ~bus.b;
          carry_d    = 1'b1;
          sliceCnt_d = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        accum_d[sliceBase +: GROUP] = sliceSum;
        carry_d    = c[GROUP];
        sliceCnt_d = sliceCnt_q + 1'b1;
        // The visible result only changes here, so it stays put during CALC.
        if (sliceCnt_q == LAST_SLICE) begin
          diff_d   = accum_d;
          borrow_d = ~c[GROUP];
`ifdef SUB_OVERFLOW_EN
          ovf_d    = c[GROUP] ^ c[GROUP-1];
`endif
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opBInv_q   <= '0;
      accum_q    <= '0;
      diff_q     <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      sliceCnt_q <= '0;
`ifdef SUB_OVERFLOW_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opBInv_q   <= opBInv_d;
      accum_q    <= accum_d;
      diff_q     <= diff_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      sliceCnt_q <= sliceCnt_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_group_subtractor.sv
// Scoreboard bench for serial_group_subtractor: directed vectors plus a
// reference-modelled random phase; define SUB_OVERFLOW_EN to also check ovf.
module tb_serial_group_subtractor;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  bit   randReady = 1'b0;
  exp_t expQ[$];

  serial_group_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_group_subtractor #(.WIDTH(WIDTH), .GROUP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Waits for in_ready, queues the expected result, then releases in_valid after the accept edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expDiff, input logic expBorrow,
                               input logic expOvf, input bit track);
    int   waitCnt;
    exp_t e;
    waitCnt = 0;
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (bus.in_ready !== 1'b1) begin
      reportTimeout("accept");
      bus.in_valid = 1'b0;
    end else begin
      if (track) begin
        e.diff   = expDiff;
        e.borrow = expBorrow;
        e.ovf    = expOvf;
        expQ.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a        = $urandom;
      bus.b        = $urandom;
    end
  endtask

  task automatic drainQueue();
    int waitCnt;
    waitCnt = 0;
    while (expQ.size() != 0 && waitCnt < 400) begin
      @(negedge clk);
      waitCnt++;
    end
    if (expQ.size() != 0) reportTimeout("drain");
  endtask

  task automatic waitOutValid(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (bus.out_valid !== 1'b1 && cycles < 50);
  endtask

  // Monitor: one pop per output handshake, so lost or duplicated results show up.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result: got diff 0x%08h with no result expected", bus.diff);
        end else begin
          e = expQ.pop_front();
          checkOutput("diff", bus.diff, e.diff);
          checkOutput("borrow", 32'(bus.borrow), 32'(e.borrow));
`ifdef SUB_OVERFLOW_EN
          checkOutput("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] ra, rb;
    logic [32:0] r;
    logic        rOvf;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_diff", bus.diff, 32'd0);
    checkOutput("reset_borrow", 32'(bus.borrow), 32'd0);

    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    applyStimulus(32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    waitOutValid(lat);
    checkOutput("latency", 32'(lat), 32'd8);
    drainQueue();

    applyStimulus(32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
    applyStimulus(32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    applyStimulus(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    drainQueue();

    // Backpressure: result must sit frozen in DONE until out_ready is pulsed.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    applyStimulus(32'h1234_5678, 32'h1111_1111, 32'h0123_4567, 1'b0, 1'b0, 1'b1);
    waitOutValid(lat);
    if (bus.out_valid !== 1'b1) reportTimeout("hold_out_valid");
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold_diff", bus.diff, 32'h0123_4567);
      checkOutput("hold_borrow", 32'(bus.borrow), 32'd0);
      checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("post_take_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("post_take_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("post_take_queue", 32'(expQ.size()), 32'd0);

    // Abort mid-calculation once the slice counter reaches 4.
    bus.out_ready = 1'b1;
    applyStimulus(32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_diff", bus.diff, 32'd0);

    applyStimulus(32'd10, 32'd4, 32'd6, 1'b0, 1'b0, 1'b1);
    drainQueue();

    randReady = 1'b1;
    for (int n = 0; n < 24; n++) begin
      ra   = $urandom;
      rb   = (n % 6 == 0) ? ra : $urandom;
      r    = {1'b0, ra} - {1'b0, rb};
      rOvf = (ra[31] ^ rb[31]) & (r[31] ^ ra[31]);
      applyStimulus(ra, rb, r[31:0], r[32], rOvf, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drainQueue();
    randReady = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("final_in_ready", 32'(bus.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
